read_return_unit: RTL and testbench

Downstream companion of the banked-memory read conflict arbiter. In every cycle, the arbiter issues at most one read: an enable, an address and a 2-bit mux code. This block carries the mux code and address through a tag pipeline that matches the fixed read latency of the memory banks. When the read data returns, the block steers it to the instruction, data or control requester with a one-cycle valid pulse. It holds the delivered word until the next delivery to that requester.

---
 rtl/read_return_unit_pkg.sv | 25 ++
 rtl/read_return_tagpipe.sv | 40 ++++
 rtl/read_return_unit.sv | 138 +++++++++++++
 tb/tb_read_return_unit.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/read_return_unit_pkg.sv
// rtl/read_return_unit_pkg.sv - shared mux codes, tag struct and counter width for the read return unit
package read_return_unit_pkg;

    localparam logic [1:0] MUX_I   = 2'd0;
    localparam logic [1:0] MUX_D   = 2'd1;
    localparam logic [1:0] MUX_C   = 2'd2;
    localparam logic [1:0] MUX_BAD = 2'd3;

    // Delivery counters saturate at all-ones of this width
    localparam int STAT_W = 16;

    // Widest address a tag can carry; narrower addresses are zero-extended
    localparam int TAG_ADDR_W = 32;

    typedef struct packed {
        logic                  valid;
        logic [1:0]            mux;
        logic [TAG_ADDR_W-1:0] addr;
    } rr_tag_t;

    function automatic logic mux_is_legal(input logic [1:0] m);
        return m != MUX_BAD;
    endfunction

endpackage

// File: rtl/read_return_tagpipe.sv
// rtl/read_return_tagpipe.sv - LATENCY-deep tag delay line with last-stage and any-valid outputs
module read_return_tagpipe
    import read_return_unit_pkg::*;
#(
    parameter int LATENCY = 2
) (
    input  logic    clk,
    input  logic    rst_n,
    input  rr_tag_t tag_in,
    output rr_tag_t tag_last,
    output logic    any_valid
);

    rr_tag_t stage [LATENCY];

    // Free-running shift: no stall, a new tag (or bubble) enters every cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= tag_in;
            for (int i = 1; i < LATENCY; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign tag_last = stage[LATENCY-1];

    // Any stage holding a live read means the unit is busy
    always_comb begin
        any_valid = 1'b0;
        for (int i = 0; i < LATENCY; i++) begin
            any_valid = any_valid | stage[i].valid;
        end
    end

endmodule

// File: rtl/read_return_unit.sv
// rtl/read_return_unit.sv - steers returning bank read data to i/d/c requesters (READ_RETURN_STATS_EN adds delivery counters)
module read_return_unit
    import read_return_unit_pkg::*;
#(
    parameter int BANKBITS = 5,
    parameter int WORDBITS = 10,
    parameter int DATABITS = 32,
    parameter int LATENCY  = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         rd_en,
    input  logic [1:0]                   rd_mux,
    input  logic [BANKBITS+WORDBITS-1:0] rd_addr,
    input  logic [DATABITS-1:0]          mem_rdata,
    output logic                         i_rvalid,
    output logic                         d_rvalid,
    output logic                         c_rvalid,
    output logic [DATABITS-1:0]          i_rdata,
    output logic [DATABITS-1:0]          d_rdata,
    output logic [DATABITS-1:0]          c_rdata,
    output logic [BANKBITS+WORDBITS-1:0] i_raddr,
    output logic [BANKBITS+WORDBITS-1:0] d_raddr,
    output logic [BANKBITS+WORDBITS-1:0] c_raddr,
    output logic                         busy,
    output logic                         err
`ifdef READ_RETURN_STATS_EN
    ,
    output logic [STAT_W-1:0]            i_cnt,
    output logic [STAT_W-1:0]            d_cnt,
    output logic [STAT_W-1:0]            c_cnt
`endif
);

    localparam int ADDR_W = BANKBITS + WORDBITS;

    rr_tag_t           tag_in;
    rr_tag_t           tag_last;
    logic              any_valid;
    logic              del_i;
    logic              del_d;
    logic              del_c;
    logic [ADDR_W-1:0] last_addr;
    logic              unused_tag_hi;

    // Illegal codes enter the pipe as bubbles so they never deliver
    always_comb begin
        tag_in       = '0;
        tag_in.valid = rd_en & mux_is_legal(rd_mux);
        tag_in.mux   = rd_mux;
        tag_in.addr  = TAG_ADDR_W'(rd_addr);
    end

    read_return_tagpipe #(
        .LATENCY (LATENCY)
    ) u_tagpipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .tag_in    (tag_in),
        .tag_last  (tag_last),
        .any_valid (any_valid)
    );

    assign last_addr     = tag_last.addr[ADDR_W-1:0];
    assign unused_tag_hi = |(tag_last.addr >> ADDR_W);
    assign busy          = any_valid;

    // Delivery demux: the last stage selects exactly one requester or none
    always_comb begin
        del_i = 1'b0;
        del_d = 1'b0;
        del_c = 1'b0;
        if (tag_last.valid) begin
            case (tag_last.mux)
                MUX_I:   del_i = 1'b1;
                MUX_D:   del_d = 1'b1;
                MUX_C:   del_c = 1'b1;
                default: ;
            endcase
        end
    end

    // Pulses last one cycle; data/address hold until the next delivery to that port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            c_rvalid <= 1'b0;
            i_rdata  <= '0;
            d_rdata  <= '0;
            c_rdata  <= '0;
            i_raddr  <= '0;
            d_raddr  <= '0;
            c_raddr  <= '0;
        end else begin
            i_rvalid <= del_i;
            d_rvalid <= del_d;
            c_rvalid <= del_c;
            if (del_i) begin
                i_rdata <= mem_rdata;
                i_raddr <= last_addr;
            end
            if (del_d) begin
                d_rdata <= mem_rdata;
                d_raddr <= last_addr;
            end
            if (del_c) begin
                c_rdata <= mem_rdata;
                c_raddr <= last_addr;
            end
        end
    end

    // Sticky illegal-code flag, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (rd_en && !mux_is_legal(rd_mux)) begin
            err <= 1'b1;
        end
    end

`ifdef READ_RETURN_STATS_EN
    // Saturating per-requester delivery counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_cnt <= '0;
            d_cnt <= '0;
            c_cnt <= '0;
        end else begin
            if (del_i && (i_cnt != '1)) i_cnt <= i_cnt + 1'b1;
            if (del_d && (d_cnt != '1)) d_cnt <= d_cnt + 1'b1;
            if (del_c && (c_cnt != '1)) c_cnt <= c_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_read_return_unit.sv
// tb/tb_read_return_unit.sv - scoreboard bench for read_return_unit
module tb_read_return_unit;
    import read_return_unit_pkg::*;

    localparam int BB  = 5;
    localparam int WB  = 10;
    localparam int DW  = 32;
    localparam int LAT = 2;
    localparam int AW  = BB + WB;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rd_en = 1'b0;
    logic [1:0]    rd_mux = 2'd0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] iss_data = '0;
    logic          i_rvalid, d_rvalid, c_rvalid;
    logic [DW-1:0] i_rdata, d_rdata, c_rdata;
    logic [AW-1:0] i_raddr, d_raddr, c_raddr;
    logic          busy, err;
`ifdef READ_RETURN_STATS_EN
    logic [STAT_W-1:0] i_cnt, d_cnt, c_cnt;
`endif

    read_return_unit #(
        .BANKBITS (BB),
        .WORDBITS (WB),
        .DATABITS (DW),
        .LATENCY  (LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_en     (rd_en),
        .rd_mux    (rd_mux),
        .rd_addr   (rd_addr),
        .mem_rdata (mem_rdata),
        .i_rvalid  (i_rvalid),
        .d_rvalid  (d_rvalid),
        .c_rvalid  (c_rvalid),
        .i_rdata   (i_rdata),
        .d_rdata   (d_rdata),
        .c_rdata   (c_rdata),
        .i_raddr   (i_raddr),
        .d_raddr   (d_raddr),
        .c_raddr   (c_raddr),
        .busy      (busy),
        .err       (err)
`ifdef READ_RETURN_STATS_EN
        ,
        .i_cnt     (i_cnt),
        .d_cnt     (d_cnt),
        .c_cnt     (c_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    mux;
        logic [DW-1:0] data;
        logic [AW-1:0] addr;
        int            cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic end_req = 1'b0;
    logic end_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: returns the issued word LAT cycles later; tracks expected busy/err
    logic [DW-1:0]  dpipe [LAT];
    logic [LAT-1:0] vpipe;
    logic           err_exp;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) dpipe[i] <= '0;
            vpipe   <= '0;
            err_exp <= 1'b0;
        end else begin
            dpipe[0] <= (rd_en && rd_mux != 2'd3) ? iss_data : (32'hBAD0_0000 ^ 32'(cyc));
            for (int i = 1; i < LAT; i++) dpipe[i] <= dpipe[i-1];
            vpipe <= {vpipe[LAT-2:0], rd_en && (rd_mux != 2'd3)};
            if (rd_en && rd_mux == 2'd3) err_exp <= 1'b1;
        end
    end
    assign mem_rdata = dpipe[LAT-1];

    // Monitor: pops the scoreboard on each delivery and checks held outputs every cycle
    initial begin
        logic [DW-1:0] sh_d [3];
        logic [AW-1:0] sh_a [3];
        int            nv;
        int            which;
        exp_t          e;
        for (int i = 0; i < 3; i++) begin sh_d[i] = '0; sh_a[i] = '0; end
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                for (int i = 0; i < 3; i++) begin sh_d[i] = '0; sh_a[i] = '0; end
                checks++;
                if ({i_rvalid, d_rvalid, c_rvalid, busy, err} != 5'b0 || {i_rdata, d_rdata, c_rdata} != '0 || {i_raddr, d_raddr, c_raddr} != '0) begin
                    errors++;
                    $display("FAIL reset_state: rv=%b%b%b busy=%b err=%b rdata=%h/%h/%h raddr=%h/%h/%h, required all 0", i_rvalid, d_rvalid, c_rvalid, busy, err, i_rdata, d_rdata, c_rdata, i_raddr, d_raddr, c_raddr);
                end
            end else begin
                nv = int'(i_rvalid) + int'(d_rvalid) + int'(c_rvalid);
                checks++;
                if (nv > 1) begin
                    errors++;
                    $display("FAIL one_hot_rvalid: rv=%b%b%b at cycle %0d, required at most one", i_rvalid, d_rvalid, c_rvalid, cyc);
                end
                checks++;
                if (busy !== (|vpipe)) begin
                    errors++;
                    $display("FAIL busy: got %b required %b at cycle %0d", busy, |vpipe, cyc);
                end
                checks++;
                if (err !== err_exp) begin
                    errors++;
                    $display("FAIL err: got %b required %b at cycle %0d", err, err_exp, cyc);
                end
                if (nv >= 1) begin
                    which = i_rvalid ? 0 : (d_rvalid ? 1 : 2);
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_rvalid: port %0d pulsed at cycle %0d, required no delivery", which, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        if (which != int'(e.mux) || cyc != e.cyc) begin
                            errors++;
                            $display("FAIL delivery: port %0d at cycle %0d, required port %0d at cycle %0d", which, cyc, e.mux, e.cyc);
                        end
                        sh_d[e.mux] = e.data;
                        sh_a[e.mux] = e.addr;
                    end
                end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL missing_rvalid: port %0d due cycle %0d, still absent at cycle %0d", exp_q[0].mux, exp_q[0].cyc, cyc);
                    void'(exp_q.pop_front());
                end
                checks++;
                if ({i_rdata, d_rdata, c_rdata} !== {sh_d[0], sh_d[1], sh_d[2]} || {i_raddr, d_raddr, c_raddr} !== {sh_a[0], sh_a[1], sh_a[2]}) begin
                    errors++;
                    $display("FAIL port_regs: rdata=%h/%h/%h raddr=%h/%h/%h, required rdata=%h/%h/%h raddr=%h/%h/%h at cycle %0d", i_rdata, d_rdata, c_rdata, i_raddr, d_raddr, c_raddr, sh_d[0], sh_d[1], sh_d[2], sh_a[0], sh_a[1], sh_a[2], cyc);
                end
                if (end_req && !end_done) begin
                    end_done = 1'b1;
                    checks++;
                    if (exp_q.size() != 0) begin
                        errors++;
                        $display("FAIL drain: %0d deliveries outstanding, required 0", exp_q.size());
                    end
`ifdef READ_RETURN_STATS_EN
                    checks++;
                    if (c_cnt !== 16'hFFFF || i_cnt !== 16'h0 || d_cnt !== 16'h0) begin
                        errors++;
                        $display("FAIL stats: i/d/c cnt=%h/%h/%h, required 0000/0000/ffff", i_cnt, d_cnt, c_cnt);
                    end
`endif
                end
            end
        end
    end

    task automatic issue(input logic [1:0] m, input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_t e;
        rd_en    = 1'b1;
        rd_mux   = m;
        rd_addr  = a;
        iss_data = d;
        if (m != 2'd3) begin
            e.mux  = m;
            e.data = d;
            e.addr = a;
            e.cyc  = cyc + LAT + 1;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
    endtask

    task automatic bubble(input int n);
        repeat (n) begin
            rd_en    = 1'b0;
            rd_mux   = 2'($urandom);
            rd_addr  = AW'($urandom);
            iss_data = $urandom;
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        exp_q.delete();
        bubble(1);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bubble(2);

        // Single i read
        issue(MUX_I, 15'h0421, 32'hDEADBEEF);
        bubble(6);

        // Back-to-back i, d, c, d
        issue(MUX_I, 15'h0010, 32'h1111_0000);
        issue(MUX_D, 15'h0020, 32'h2222_0000);
        issue(MUX_C, 15'h7FFF, 32'h3333_0000);
        issue(MUX_D, 15'h0040, 32'h4444_0000);
        bubble(6);

        // Illegal code, then legal reads with err held
        issue(MUX_BAD, 15'h0123, 32'h5555_5555);
        bubble(4);
        issue(MUX_C, 15'h0055, 32'hCAFE_F00D);
        issue(MUX_I, 15'h0000, 32'h0000_0001);
        bubble(6);

        // Reset with two reads in flight
        issue(MUX_D, 15'h0777, 32'hAAAA_AAAA);
        issue(MUX_I, 15'h0666, 32'hBBBB_BBBB);
        pulse_reset();
        bubble(6);

        // d reads separated by bubbles
        issue(MUX_D, 15'h0101, 32'h0D00_0001);
        bubble(1);
        issue(MUX_D, 15'h0102, 32'h0D00_0002);
        bubble(2);
        issue(MUX_D, 15'h0103, 32'h0D00_0003);
        issue(MUX_D, 15'h0104, 32'h0D00_0004);
        bubble(3);
        issue(MUX_D, 15'h0105, 32'h0D00_0005);
        bubble(6);

`ifdef READ_RETURN_STATS_EN
        pulse_reset();
        bubble(2);
        for (int k = 0; k < 70000; k++) begin
            issue(MUX_C, AW'(k), 32'(k));
        end
        bubble(6);
`endif

        end_req = 1'b1;
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
